// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared MIPS pipeline definitions used by the forwarding/hazard controller.
//   - opcode constants for the loads and the store word instruction
//   - is_load(): true for any opcode whose result only becomes forwardable late
//   - wtag_t: one in-flight register-writer tag {valid, rd, ld}
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       ld;
  } wtag_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

endpackage

// File: rtl/pipe_forward_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_forward_ctrl_if
// Bundles the issue-slot inputs and the forwarding/stall outputs of
// pipe_forward_ctrl.
//   master : the pipeline side (drives issue_*, src_*, flush; reads results)
//   slave  : the controller side
//
// Handshake: issue_valid qualifies issue_op/we/rd and src_reg/src_used in the
// same cycle. stall acts as an inverted ready: a slot presented while stall is
// high is not accepted at the next edge and must be held unchanged by the
// master until a cycle with stall low. flush is unconditional and has priority.
// -----------------------------------------------------------------------------
interface pipe_forward_ctrl_if #(
  parameter int NUM_SRC = 2,
  parameter int SEL_W   = 2
);
  logic                     issue_valid;
  logic [5:0]               issue_op;
  logic                     issue_we;
  logic [4:0]               issue_rd;
  logic [NUM_SRC*5-1:0]     src_reg;
  logic [NUM_SRC-1:0]       src_used;
  logic                     flush;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic [15:0]              stall_count;

  modport master (
    output issue_valid, issue_op, issue_we, issue_rd, src_reg, src_used, flush,
    input  fwd_sel, stall, stall_count
  );

  modport slave (
    input  issue_valid, issue_op, issue_we, issue_rd, src_reg, src_used, flush,
    output fwd_sel, stall, stall_count
  );
endinterface

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Combinational priority match of one source register against all tracked
// writer stages. The youngest matching stage wins.
//   tags     : writer tags, index 0 = youngest (EX/MEM)
//   src_reg  : source register number
//   src_used : source is actually read
//   is_sw    : entering instruction is a store word
//   sel      : 0 = register file, k = forward from stage k-1
//   hazard   : matched writer is a load whose data is not yet available
// -----------------------------------------------------------------------------
module fwd_match
  import mips_pkg::*;
#(
  parameter int DEPTH         = 3,
  parameter int LOAD_LAT      = 1,
  parameter int SEL_W         = 2,
  parameter bit IS_STORE_PORT = 1'b0
) (
  input  wtag_t [DEPTH-1:0] tags,
  input  logic [4:0]        src_reg,
  input  logic              src_used,
  input  logic              is_sw,
  output logic [SEL_W-1:0]  sel,
  output logic              hazard
);

  logic found;
  int   lim;

  always_comb begin
    sel    = '0;
    hazard = 1'b0;
    found  = 1'b0;
    // Store data is consumed in MEM, one stage later than ALU operands, so a
    // load one stage older is already forwardable for that operand.
    lim    = (IS_STORE_PORT && is_sw) ? (LOAD_LAT - 1) : LOAD_LAT;
    for (int k = 0; k < DEPTH; k++) begin
      if (!found && tags[k].valid && (tags[k].rd == src_reg)) begin
        found  = 1'b1;
        sel    = SEL_W'(k + 1);
        hazard = tags[k].ld && (k < lim);
      end
    end
    // $0 is hard-wired and unused operands never forward or stall.
    if (!src_used || (src_reg == 5'd0)) begin
      sel    = '0;
      hazard = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_forward_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_forward_ctrl
// Forwarding and load-use hazard controller beside the ID/EX boundary.
// Tracks in-flight register writers in a DEPTH-stage tag pipeline, drives a
// forward select per source operand, stalls on load-use hazards and counts
// stall cycles (saturating at 16'hFFFF).
//   clock   : pipeline clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : slave side of pipe_forward_ctrl_if (issue slot in, selects out)
// LOAD_LAT must satisfy 1 <= LOAD_LAT < DEPTH.
// -----------------------------------------------------------------------------
module pipe_forward_ctrl
  import mips_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1,
  parameter int STORE_PORT = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  pipe_forward_ctrl_if.slave    bus
);

  wtag_t [DEPTH-1:0]        tags_q, tags_d;
  logic  [15:0]             stall_count_q, stall_count_d;
  logic  [NUM_SRC-1:0]      hazard;
  logic  [SEL_W-1:0]        sel_w [NUM_SRC];
  logic  [NUM_SRC*SEL_W-1:0] fwd_sel_w;
  logic                     is_sw;
  logic                     stall;

  assign is_sw = (bus.issue_op == OP_SW);

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
    fwd_match #(
      .DEPTH         (DEPTH),
      .LOAD_LAT      (LOAD_LAT),
      .SEL_W         (SEL_W),
      .IS_STORE_PORT (g == STORE_PORT)
    ) u_match (
      .tags     (tags_q),
      .src_reg  (bus.src_reg[5*g +: 5]),
      .src_used (bus.src_used[g]),
      .is_sw    (is_sw),
      .sel      (sel_w[g]),
      .hazard   (hazard[g])
    );
  end

  always_comb begin
    fwd_sel_w = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_sel_w[i*SEL_W +: SEL_W] = sel_w[i];
    end
  end

  // Flush squashes the instruction in EX, so it must not stall either.
  assign stall = bus.issue_valid & (|hazard) & ~bus.flush;

  assign bus.fwd_sel     = fwd_sel_w;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_count_q;

  always_comb begin
    tags_d        = tags_q;
    stall_count_d = stall_count_q;
    if (bus.flush) begin
      for (int s = 0; s < DEPTH; s++) begin
        tags_d[s].valid = 1'b0;
      end
    end else begin
      for (int s = DEPTH - 1; s > 0; s--) begin
        tags_d[s] = tags_q[s-1];
      end
      // A stalled slot is not accepted: a bubble enters stage 0 instead.
      tags_d[0].valid = bus.issue_valid & bus.issue_we &
                        (bus.issue_rd != 5'd0) & ~stall;
      tags_d[0].rd    = bus.issue_rd;
      tags_d[0].ld    = is_load(bus.issue_op);
    end
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tags_q        <= '0;
      stall_count_q <= 16'd0;
    end else begin
      tags_q        <= tags_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: doc/pipe_forward_ctrl.md
# pipe_forward_ctrl

Parametrised forwarding and hazard controller for the MIPS pipeline. It generalises the single store-data forward check into a per-operand forward select for any number of source ports, across a configurable number of downstream stages. It tracks in-flight register writers in an internal tag pipeline, detects load-use hazards, inserts bubbles, and counts stall cycles. It sits beside the ID/EX boundary: it receives the instruction entering EX and drives the EX-stage operand muxes and the pipeline stall line.

## Interface
- NUM_SRC, 2: number of source-register operands checked per instruction.
- DEPTH, 3: writer stages tracked after EX. Stage 0 = EX/MEM, stage DEPTH-1 = oldest.
- LOAD_LAT, 1: number of youngest stages in which a load result is not yet forwardable. Must satisfy 1 ≤ LOAD_LAT < DEPTH.
- STORE_PORT, 1: source index that carries store data. It is consumed one stage late.
- SEL_W, $clog2(DEPTH+1): width of each forward select (derived).

Ports:
- clock in 1: pipeline clock, rising edge.
- reset_n in 1: asynchronous, active-low reset.
- issue_valid in 1: an instruction is entering EX this cycle.
- issue_op in 6: opcode of the entering instruction.
- issue_we in 1: the entering instruction writes a register.
- issue_rd in 5: destination register of the entering instruction.
- src_reg in NUM_SRC*5: source registers. Port i occupies bits [5i+4:5i].
- src_used in NUM_SRC: source i is actually read.
- flush in 1: squash all tracked writers (branch/exception).
- fwd_sel out NUM_SRC*SEL_W: per-source value. 0 = register file; k = forward from stage k-1.
- stall out 1: hold IF/ID and this issue slot; insert a bubble into EX.
- stall_count out 16: saturating count of stall cycles since reset.

## Operation
- Tag pipeline: each stage s holds valid[s], rd[s] and ld[s]. ld is set when the opcode is in the package load set (LB, LH, LW, LBU, LHU).
- Update at each edge, when not flushing:
  - stages 1..DEPTH-1 shift from s-1;
  - stage 0 loads {issue_valid & issue_we & (issue_rd≠0) & ~stall, issue_rd, is_load(issue_op)}.
  - A stalled cycle therefore shifts a bubble into stage 0.
- flush: every valid clears at the edge, and no new tag enters that edge. Flush wins over stall and over issue.
- Forward select for source i:
  - fwd_sel[i] = k+1 for the smallest k where valid[k] and rd[k]==src_reg[i]. Youngest writer wins.
  - fwd_sel[i] = 0 when src_reg[i]==0, when src_used[i]==0, or when there is no match.
- Load-use hazard for source i: src_used[i], src_reg[i]≠0, and the youngest matching stage k<LOAD_LAT has ld[k].
  - Exemption: when issue_op==OP_SW and i==STORE_PORT, the hazard applies only for k<LOAD_LAT-1. Store data forwards at MEM.
- stall = issue_valid & OR of all source hazards & ~flush.
- stall_count increments on each edge where stall==1. It holds at 16'hFFFF.

## Timing
- fwd_sel and stall are combinational from registered tags and current inputs. There is no added latency, and they are valid in the same cycle as issue.
- A writer issued at edge t is visible in stage 0 from t until t+1, and drops out after DEPTH edges.
- A load followed immediately by a dependent ALU op (LOAD_LAT=1) gives one stall cycle. The next cycle forwards with fwd_sel=2.
- Reset (reset_n low, asynchronous): all valid=0, stall_count=0. Therefore fwd_sel=0 and stall=0 immediately, and this holds while reset is low. Reset mid-stall drops stall at once.
- Simultaneous flush and stall: stall is forced to 0 and tags are cleared.

## Structure
- Shared package mips_pkg holds:
  - opcode constants OP_LB=6'h20, OP_LH=6'h21, OP_LW=6'h23, OP_LBU=6'h24, OP_LHU=6'h25, OP_SW=6'h2B;
  - the is_load function;
  - a writer-tag struct {valid, rd[4:0], ld}.
- One sub-module, fwd_match, is instantiated NUM_SRC times. It is a combinational priority match of one source against all stages and returns sel and hazard.

## Test plan
- Writer add $8, then add using $8 on port 0 in the next cycle → fwd_sel[0]=1, stall=0. One cycle later (no new writer) → fwd_sel[0]=2.
- lw $9, then add reading $9 → stall=1 for exactly 1 cycle, stall_count=1. After the bubble, fwd_sel=2.
- lw $9, then sw with data $9 on STORE_PORT, base $4 → stall=0, fwd_sel[1]=1, fwd_sel[0]=0.
- Two writers of $5 in consecutive cycles, then a read of $5 → fwd_sel=1 (youngest). Source $0 with a writer rd=0 issued → fwd_sel=0.
- Load hazard pending, assert flush → stall=0 that cycle, all fwd_sel=0 the next cycle.
- Force 65540 hazard cycles → stall_count saturates at 16'hFFFF. Pulse reset_n low between edges → count=0 and stall=0 asynchronously.
